// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_BUS_W  = 32;
   localparam int RF_MAX_RD = 8;

   // Register 0 is hard-wired to zero when zero_reg is set, so it can never be
   // written or marked pending.
   function automatic logic is_writable(input logic [31:0] addr, input logic zero_reg);
      return !(zero_reg && (addr == 32'd0));
   endfunction

endpackage

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register pending scoreboard: issue marks a destination busy, writeback clears it.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR     = RF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic                    reloj,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [ADDR-1:0]         wr_addr,
   input  logic                    mark_en,
   input  logic [ADDR-1:0]         mark_addr,
   output logic [(1<<ADDR)-1:0]    busy,
   output logic                    mark_ok,
   output logic [ADDR:0]           busy_cnt
);

   localparam int DEPTH = 1 << ADDR;

   logic [DEPTH-1:0] busy_q, busy_d;
   logic [ADDR:0]    cnt_q, cnt_d;
   logic             wr_eff, mark_eff, same_addr, cnt_inc, cnt_dec;

   // Accept/apply marks and clears; a same-cycle write to the marked address
   // counts as a clear, so the mark is accepted and the bit ends set.
   always_comb begin
      same_addr = wr_en && (wr_addr == mark_addr);
      mark_ok   = !mark_en
                  || !is_writable(32'(mark_addr), ZERO_REG != 0)
                  || !busy_q[mark_addr]
                  || same_addr;
      wr_eff    = wr_en && is_writable(32'(wr_addr), ZERO_REG != 0);
      mark_eff  = mark_en && mark_ok && is_writable(32'(mark_addr), ZERO_REG != 0);

      busy_d = busy_q;
      if (wr_eff)   busy_d[wr_addr]   = 1'b0;
      if (mark_eff) busy_d[mark_addr] = 1'b1;

      // The counter tracks the popcount: a clear that is overridden by a mark
      // on the same address is not a real clear.
      cnt_inc = mark_eff && !busy_q[mark_addr];
      cnt_dec = wr_eff && busy_q[wr_addr] && !(mark_eff && (mark_addr == wr_addr));

      cnt_d = cnt_q;
      if (cnt_inc && !cnt_dec)      cnt_d = cnt_q + (ADDR+1)'(1);
      else if (cnt_dec && !cnt_inc) cnt_d = cnt_q - (ADDR+1)'(1);
   end

   // Scoreboard state register; reset overrides any same-cycle mark/write.
   always_ff @(posedge reloj) begin
      if (reset) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   assign busy     = busy_q;
   assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Single-write, N-read register file with optional write-to-read bypass and a
// busy scoreboard shared between issue (mark) and writeback (clear).
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int ADDR     = RF_ADDR_W,
   parameter int BUS_W    = RF_BUS_W,
   parameter int NUM_RD   = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                    reloj,
   input  logic                    reset,
   input  logic [NUM_RD*ADDR-1:0]  rd_addr,
   output logic [NUM_RD*BUS_W-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_busy,
   input  logic                    wr_en,
   input  logic [ADDR-1:0]         wr_addr,
   input  logic [BUS_W-1:0]        wr_data,
   input  logic                    mark_en,
   input  logic [ADDR-1:0]         mark_addr,
   output logic                    mark_ok,
   output logic [ADDR:0]           busy_cnt
);

   localparam int DEPTH = 1 << ADDR;

   if (NUM_RD < 1 || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
      $error("regfile_mp_sb: NUM_RD must be within 1..%0d", RF_MAX_RD);
   end

   logic [BUS_W-1:0] mem_q [DEPTH];
   logic [BUS_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_vec;

   rf_scoreboard #(
      .ADDR     (ADDR),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .reloj     (reloj),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .busy      (busy_vec),
      .mark_ok   (mark_ok),
      .busy_cnt  (busy_cnt)
   );

   // Next data array: the writeback port updates one register per cycle.
   always_comb begin
      mem_d = mem_q;
      if (wr_en && is_writable(32'(wr_addr), ZERO_REG != 0))
         mem_d[wr_addr] = wr_data;
   end

   // Data array register.
   always_ff @(posedge reloj) begin
      if (reset) mem_q <= '{default: '0};
      else       mem_q <= mem_d;
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR-1:0]  a;
      logic [BUS_W-1:0] data;
      logic             bsy;

      // Read mux: zero register, then same-cycle bypass, then stored state.
      // A bypassed reader is older than any same-cycle mark, so it sees not-busy.
      always_comb begin
         a    = rd_addr[i*ADDR +: ADDR];
         data = mem_q[a];
         bsy  = busy_vec[a];
         if (!is_writable(32'(a), ZERO_REG != 0)) begin
            data = '0;
            bsy  = 1'b0;
         end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
            data = wr_data;
            bsy  = 1'b0;
         end
      end

      assign rd_data[i*BUS_W +: BUS_W] = data;
      assign rd_busy[i]                = bsy;
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb (ADDR=5, BUS_W=32, NUM_RD=2, BYPASS=1, ZERO_REG=1).
module tb_regfile_mp_sb;

   logic        reloj = 1'b0;
   logic        reset;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        mark_en;
   logic [4:0]  mark_addr;
   logic        mark_ok;
   logic [5:0]  busy_cnt;

   int n_cmp = 0;
   int n_err = 0;

   regfile_mp_sb #(
      .ADDR(5), .BUS_W(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)
   ) dut (
      .reloj     (reloj),
      .reset     (reset),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .mark_en   (mark_en),
      .mark_addr (mark_addr),
      .mark_ok   (mark_ok),
      .busy_cnt  (busy_cnt)
   );

   always #5 reloj = ~reloj;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are changed 1 time unit after the edge.
   task automatic step();
      @(posedge reloj);
      #1;
   endtask

   task automatic idle();
      wr_en   = 1'b0;
      mark_en = 1'b0;
   endtask

   function automatic logic [31:0] d0();
      return rd_data[31:0];
   endfunction

   function automatic logic [31:0] d1();
      return rd_data[63:32];
   endfunction

   initial begin
      reset     = 1'b1;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      mark_en   = 1'b0;
      mark_addr = '0;
      step();
      step();
      reset = 1'b0;

      // 1. state after reset
      rd_addr = {5'd31, 5'd3};
      #1;
      check("rst_rd0",   d0(), 32'h0);
      check("rst_rd1",   d1(), 32'h0);
      check("rst_busy",  32'(rd_busy), 32'h0);
      check("rst_cnt",   32'(busy_cnt), 32'h0);
      check("rst_mok",   32'(mark_ok), 32'h1);

      // 2. write with same-cycle bypass on both ports
      wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
      rd_addr = {5'd5, 5'd5};
      #1;
      check("byp_rd0",   d0(), 32'hDEADBEEF);
      check("byp_rd1",   d1(), 32'hDEADBEEF);
      check("byp_busy",  32'(rd_busy), 32'h0);
      step();
      idle();
      #1;
      check("wr_rd0",    d0(), 32'hDEADBEEF);
      check("wr_cnt",    32'(busy_cnt), 32'h0);

      // 3. zero register ignores writes and marks
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
      mark_en = 1'b1; mark_addr = 5'd0;
      rd_addr = {5'd5, 5'd0};
      #1;
      check("z_rd0",     d0(), 32'h0);
      check("z_mok",     32'(mark_ok), 32'h1);
      step();
      idle();
      #1;
      check("z_rd0_aft", d0(), 32'h0);
      check("z_busy",    32'(rd_busy[0]), 32'h0);
      check("z_cnt",     32'(busy_cnt), 32'h0);

      // 4. mark 7, remark rejected, writeback clears
      mark_en = 1'b1; mark_addr = 5'd7;
      rd_addr = {5'd7, 5'd7};
      #1;
      check("m7_mok",    32'(mark_ok), 32'h1);
      check("m7_busy0",  32'(rd_busy), 32'h0);
      step();
      idle();
      #1;
      check("m7_busy",   32'(rd_busy), 32'h3);
      check("m7_cnt",    32'(busy_cnt), 32'h1);
      mark_en = 1'b1; mark_addr = 5'd7;
      #1;
      check("m7_remok",  32'(mark_ok), 32'h0);
      step();
      idle();
      #1;
      check("m7_recnt",  32'(busy_cnt), 32'h1);
      check("m7_rebusy", 32'(rd_busy[0]), 32'h1);
      wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
      #1;
      check("w7_byp",    d1(), 32'hA5);
      check("w7_bypbsy", 32'(rd_busy), 32'h0);
      step();
      idle();
      #1;
      check("w7_rd",     d0(), 32'hA5);
      check("w7_busy",   32'(rd_busy), 32'h0);
      check("w7_cnt",    32'(busy_cnt), 32'h0);

      // 5. same-cycle write+mark on a busy register
      mark_en = 1'b1; mark_addr = 5'd9;
      step();
      idle();
      rd_addr = {5'd7, 5'd9};
      #1;
      check("m9_cnt",    32'(busy_cnt), 32'h1);
      check("m9_busy",   32'(rd_busy[0]), 32'h1);
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
      mark_en = 1'b1; mark_addr = 5'd9;
      #1;
      check("wm9_mok",   32'(mark_ok), 32'h1);
      check("wm9_rd",    d0(), 32'h55);
      check("wm9_bsy",   32'(rd_busy[0]), 32'h0);
      step();
      idle();
      #1;
      check("wm9_rdaft", d0(), 32'h55);
      check("wm9_bsyaf", 32'(rd_busy[0]), 32'h1);
      check("wm9_cnt",   32'(busy_cnt), 32'h1);

      // clear 9 while marking a free register 10 in the same cycle
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h66;
      mark_en = 1'b1; mark_addr = 5'd10;
      step();
      idle();
      rd_addr = {5'd10, 5'd9};
      #1;
      check("x_cnt",     32'(busy_cnt), 32'h1);
      check("x_busy",    32'(rd_busy), 32'h2);
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0;
      step();
      idle();
      #1;
      check("x_cnt0",    32'(busy_cnt), 32'h0);

      // 6. reset mid-operation with a pending write and mark
      for (int k = 1; k <= 4; k++) begin
         wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'h100 + 32'(k);
         step();
      end
      idle();
      for (int k = 1; k <= 4; k++) begin
         mark_en = 1'b1; mark_addr = 5'(k);
         step();
      end
      idle();
      rd_addr = {5'd4, 5'd3};
      #1;
      check("pre_cnt",   32'(busy_cnt), 32'h4);
      check("pre_rd3",   d0(), 32'h103);
      check("pre_rd4",   d1(), 32'h104);
      check("pre_busy",  32'(rd_busy), 32'h3);
      reset = 1'b1;
      wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hFFFF;
      mark_en = 1'b1; mark_addr = 5'd5;
      step();
      reset = 1'b0;
      idle();
      check("post_cnt",  32'(busy_cnt), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         rd_addr = {5'(k), 5'(k)};
         #1;
         check($sformatf("post_rd%0d", k),   d0(), 32'h0);
         check($sformatf("post_bsy%0d", k),  32'(rd_busy), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the single-write, dual-read CPU register file. It adds:
- N read ports, each with an optional write-to-read bypass.
- A per-register busy scoreboard. The issue stage marks a destination register pending; writeback clears it.
- A busy counter.

It sits between decode/issue (reads, marks) and writeback (writes) in the pipelined core.

Parameters:
ADDR, 5, register address width; depth = 2**ADDR
BUS_W, 32, data width
NUM_RD, 2, number of read ports (1..8)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = write visible next cycle
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/marks

Ports:
reloj  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state
rd_addr  in  NUM_RD*ADDR  packed read addresses, port i = bits [i*ADDR +: ADDR]
rd_data  out  NUM_RD*BUS_W  packed read data, combinational
rd_busy  out  NUM_RD  per-port pending flag for the addressed register, combinational
wr_en  in  1  writeback strobe
wr_addr  in  ADDR  writeback address
wr_data  in  BUS_W  writeback data
mark_en  in  1  issue strobe: set destination pending
mark_addr  in  ADDR  destination to mark
mark_ok  out  1  combinational; mark accepted this cycle
busy_cnt  out  ADDR+1  number of pending registers

Behaviour:
- Reset (synchronous, sampled at reloj edge, overrides all same-cycle wr/mark):
  - all registers 0, all busy bits 0, busy_cnt 0.
  - Combinational outputs follow state: rd_data 0, rd_busy 0, mark_ok = 1 whenever mark_en is low or the target is free.
- Write: if wr_en and not (ZERO_REG and wr_addr == 0):
  - mem[wr_addr] <= wr_data.
  - busy[wr_addr] <= 0.
  - A write to a non-busy register is legal; the busy bit stays 0.
- Read, port i, a = rd_addr[i]:
  - ZERO_REG and a == 0 -> rd_data 0, rd_busy 0.
  - BYPASS=1, wr_en, wr_addr == a, a is writable -> rd_data = wr_data, rd_busy = 0.
  - Otherwise -> rd_data = mem[a], rd_busy = busy[a].
  - Zero-cycle latency. With BYPASS=0 a written value appears one cycle after the write, and rd_busy reflects the pre-write busy bit.
- Mark:
  - mark_ok = ~mark_en | (ZERO_REG & mark_addr == 0) | ~busy[mark_addr] | (wr_en & wr_addr == mark_addr).
  - A write to the same address in the same cycle counts as clearing, so back-to-back reuse is allowed.
  - If mark_en & mark_ok & target writable -> busy[mark_addr] <= 1.
  - If mark_ok = 0, there is no state change; issue must hold and retry.
- Simultaneous write and mark to the same address: the data is written and the busy bit ends at 1 (mark wins over clear). rd_busy that cycle reads 0 when BYPASS=1, because the reader is older than the marking instruction.
- busy_cnt:
  - +1 on an effective set of a previously clear bit.
  - −1 on an effective clear of a previously set bit.
  - Same-address write+mark with the bit already set -> net 0.
  - Never wraps; max 2**ADDR (ZERO_REG=1: 2**ADDR − 1).
- Multiple read ports with the same address return identical values.
- Out-of-range parameters (NUM_RD outside 1..8) are a compile-time error.

Decomposition:
- Package regfile_pkg:
  - default constants RF_ADDR_W = 5, RF_BUS_W = 32, RF_MAX_RD = 8.
  - function is_writable(addr, zero_reg).
- Sub-module rf_scoreboard (ADDR, ZERO_REG):
  - owns the busy vector, mark_ok and busy_cnt.
  - inputs: wr_en/wr_addr, mark_en/mark_addr, reloj, reset.
  - exposes the busy vector to the read muxes.
- The data array and read/bypass muxes (generate loop over NUM_RD) stay in the top.

Test Plan:
1. Reset then read: assert reset 1 cycle; read ports 0..1 at addrs 3, 31 -> rd_data 0, rd_busy 0, busy_cnt 0.
2. Write/read, BYPASS=1: wr_en, wr_addr=5, wr_data=0xDEADBEEF, rd_addr[0]=5 same cycle -> rd_data[0]=0xDEADBEEF that cycle and after. BYPASS=0 build: old value (0) that cycle, 0xDEADBEEF next cycle.
3. Zero register: write 0x1234 to addr 0 and mark_en addr 0 -> rd_data 0, mark_ok 1, busy_cnt unchanged at 0.
4. Scoreboard:
   - mark addr 7 -> next cycle rd_busy 1 for port reading 7, busy_cnt 1.
   - mark 7 again -> mark_ok 0, no change.
   - write 7 = 0xA5 -> busy clears next cycle, busy_cnt 0.
5. Same-cycle write+mark on 9 (busy=1): wr 9 = 0x55 and mark 9 -> mark_ok 1, mem[9]=0x55, busy[9] stays 1, busy_cnt unchanged; port reading 9 that cycle sees 0x55, rd_busy 0.
6. Reset mid-operation: registers 1..4 marked (busy_cnt 4) and data written; reset asserted together with wr_en/mark_en -> next cycle all data 0, all busy 0, busy_cnt 0, no write taken.
